// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared state encoding and constants for the UART transmit arbiter.
package uart_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
    localparam int NUM_REQ = 2;
    localparam int DEF_START_TIMEOUT = 16;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: two-way round-robin winner select; on a tie the lane that did not go last wins.
module uart_rr_pick
    import uart_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] full,
    input  logic               lastGrant,
    output logic [NUM_REQ-1:0] winner
);
    always_comb winner = &full ? (lastGrant ? 2'b01 : 2'b10) : full;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one Uart8 transmitter between two single-byte requesters,
// with a start-acknowledge timeout and per-requester done/error pulses.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqByte,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [NUM_REQ-1:0]   reqDone,
    output logic [NUM_REQ-1:0]   reqErr,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 txEn,
    output logic                 txStart,
    output logic [7:0]           txByte,
    input  logic                 txBusy,
    input  logic                 txDone
);
    localparam int TW = START_TIMEOUT > 1 ? $clog2(START_TIMEOUT) : 1;
    state_t state, next;
    logic [NUM_REQ-1:0] full, winner;
    logic [7:0] slot [NUM_REQ];
    logic [TW-1:0] timer;
    logic last_grant, fin_done, fin_err, fin;
    uart_rr_pick u_pick (.full(full), .lastGrant(last_grant), .winner(winner));
    assign reqReady = ~full;
    // Completion/error are decoded in the finishing cycle; gating with rstN keeps a reset edge pulse-free.
    always_comb begin
        fin_done = rstN && (state == WAIT_BUSY || state == WAIT_DONE) && txDone;
        fin_err = rstN && state == WAIT_BUSY && !txDone && !txBusy && timer == TW'(START_TIMEOUT - 1);
        fin = fin_done || fin_err;
        next = state == IDLE ? (|full ? START : IDLE) :
               state == START ? WAIT_BUSY :
               fin ? IDLE :
               (state == WAIT_BUSY && txBusy) ? WAIT_DONE : state;
        txStart = state == START;
        reqDone = fin_done ? grant : '0;
        reqErr = fin_err ? grant : '0;
    end
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= IDLE;
            full <= '0;
            timer <= '0;
            last_grant <= 1'b1;
            grant <= '0;
            txByte <= 8'h00;
            txEn <= 1'b0;
        end else begin
            state <= next;
            txEn <= 1'b1;
            full <= (full | (reqValid & ~full)) & ~(fin ? grant : '0);
            for (int i = 0; i < NUM_REQ; i++)
                if (reqValid[i] && !full[i]) slot[i] <= reqByte[8*i +: 8];
            if (state == IDLE && |full) begin
                grant <= winner;
                txByte <= slot[winner[1]];
            end
            if (fin) begin
                grant <= '0;
                last_grant <= grant[1];
            end
            timer <= (state == WAIT_BUSY && next == WAIT_BUSY) ? timer + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios against a Uart8 model, with a grant/byte scoreboard
// popped on every txStart.
module tb_uart_tx_arbiter;
    typedef struct packed {logic [1:0] g; logic [7:0] b;} exp_t;
    logic clk = 1'b0, rstN = 1'b0, nobusy = 1'b0;
    logic [1:0] reqValid = '0;
    logic [15:0] reqByte = '0;
    logic [1:0] reqReady, reqDone, reqErr, grant, cur_grant = '0;
    logic txEn, txStart, txBusy, txDone;
    logic [7:0] txByte;
    exp_t exp_q[$];
    int compared = 0, mismatched = 0, cyc = 0, cnt = 0, done_at = 20;
    int n_start = 0, n_done = 0, n_err = 0, t_start = 0, t_err = 0, last_fin = -100;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.START_TIMEOUT(16)) dut (
        .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqByte(reqByte), .reqReady(reqReady),
        .reqDone(reqDone), .reqErr(reqErr), .grant(grant), .txEn(txEn), .txStart(txStart),
        .txByte(txByte), .txBusy(txBusy), .txDone(txDone)
    );

    // Uart8 model: busy from the cycle after txStart, done pulse done_at cycles after txStart.
    assign txBusy = !nobusy && cnt >= 1 && cnt <= done_at;
    assign txDone = !nobusy && cnt == done_at;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        cnt <= txStart ? 1 : (cnt > 0 && cnt < 40) ? cnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        reqValid = '0;
        run(2);
        rstN = 1'b1;
        run(1);
    endtask

    always @(negedge clk) if (rstN) begin
        exp_t e;
        if (txStart) begin
            check("sb_expected_start", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_grant", grant, e.g);
                check("sb_txByte", txByte, e.b);
            end
            check("sb_idle_gap", (cyc - last_fin) >= 2, 1);
            cur_grant = grant;
            n_start++;
            t_start = cyc;
        end
        if (reqDone != 0) begin
            check("sb_reqDone_lane", reqDone, cur_grant);
            n_done++;
            last_fin = cyc;
        end
        if (reqErr != 0) begin
            check("sb_reqErr_lane", reqErr, cur_grant);
            n_err++;
            t_err = cyc;
            last_fin = cyc;
        end
    end

    initial begin
        run(3);
        check("rst_txStart", txStart, 0);
        check("rst_txEn", txEn, 0);
        check("rst_txByte", txByte, 8'h00);
        check("rst_grant", grant, 0);
        check("rst_reqDone", reqDone, 0);
        check("rst_reqErr", reqErr, 0);
        check("rst_reqReady", reqReady, 2'b11);
        rstN = 1'b1;
        run(1);
        check("txEn_after_reset", txEn, 1);
        // single byte on lane 0, two-cycle start latency
        reqValid = 2'b01; reqByte = 16'h00D6;
        exp_q.push_back(exp_t'{2'b01, 8'hD6});
        run(1);
        reqValid = '0;
        check("s1_ready_loaded", reqReady, 2'b10);
        check("s1_no_start_yet", txStart, 0);
        run(1);
        check("s1_start", txStart, 1);
        check("s1_grant", grant, 2'b01);
        check("s1_txByte", txByte, 8'hD6);
        run(25);
        check("s1_done_count", n_done, 1);
        check("s1_ready_back", reqReady, 2'b11);
        check("s1_grant_idle", grant, 0);
        // both lanes on one edge after reset: lane 0 first
        do_reset();
        reqValid = 2'b11; reqByte = 16'h3CA5;
        exp_q.push_back(exp_t'{2'b01, 8'hA5});
        exp_q.push_back(exp_t'{2'b10, 8'h3C});
        run(1);
        reqValid = '0;
        check("s2_both_full", reqReady, 2'b00);
        run(60);
        check("s2_starts", n_start, 3);
        check("s2_dones", n_done, 3);
        // lane 0 reloading continuously while lane 1 waits
        reqValid = 2'b11; reqByte = 16'h1120;
        exp_q.push_back(exp_t'{2'b01, 8'h20});
        exp_q.push_back(exp_t'{2'b10, 8'h11});
        exp_q.push_back(exp_t'{2'b01, 8'h20});
        run(1);
        reqValid = 2'b01;
        for (int i = 0; i < 200 && n_start < 6; i++) run(1);
        check("s3_three_grants", n_start, 6);
        reqValid = '0;
        run(30);
        check("s3_dones", n_done, 6);
        check("s3_ready_back", reqReady, 2'b11);
        // start timeout: txBusy never rises
        nobusy = 1'b1;
        reqValid = 2'b10; reqByte = 16'h7700;
        exp_q.push_back(exp_t'{2'b10, 8'h77});
        run(1);
        reqValid = '0;
        run(25);
        check("s4_err_count", n_err, 1);
        check("s4_err_latency", t_err - t_start, 16);
        check("s4_no_done", n_done, 6);
        check("s4_slot_cleared", reqReady, 2'b11);
        nobusy = 1'b0;
        // reset while the frame is in WAIT_DONE
        reqValid = 2'b01; reqByte = 16'h005A;
        exp_q.push_back(exp_t'{2'b01, 8'h5A});
        run(1);
        reqValid = '0;
        run(6);
        check("s5_granted", grant, 2'b01);
        rstN = 1'b0;
        run(1);
        check("s5_txStart", txStart, 0);
        check("s5_txEn", txEn, 0);
        check("s5_txByte", txByte, 8'h00);
        check("s5_grant", grant, 0);
        check("s5_reqDone", reqDone, 0);
        check("s5_reqErr", reqErr, 0);
        check("s5_reqReady", reqReady, 2'b11);
        rstN = 1'b1;
        run(25);
        check("s5_no_done", n_done, 6);
        check("s5_no_err", n_err, 1);
        // txDone together with txBusy in WAIT_BUSY
        done_at = 1;
        reqValid = 2'b10; reqByte = 16'h9900;
        exp_q.push_back(exp_t'{2'b10, 8'h99});
        run(1);
        reqValid = '0;
        run(8);
        check("s6_one_done", n_done, 7);
        check("s6_idle_grant", grant, 0);
        check("s6_ready_back", reqReady, 2'b11);
        done_at = 20;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
